// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared IRQ codes, format codes and sequencer state encoding
package monitor_pkg;

    localparam logic [7:0] IRQ_BOOT  = 8'hFD;
    localparam logic [7:0] IRQ_ID    = 8'hFB;
    localparam logic [7:0] IRQ_READY = 8'hEF;
    localparam logic [7:0] IRQ_FMT   = 8'hDF;
    localparam logic [7:0] IRQ_IDLE  = 8'hFF;

    localparam logic [7:0] FMT_NONE = 8'h00;
    localparam logic [7:0] FMT_576I = 8'h01;
    localparam logic [7:0] FMT_480I = 8'h02;
    localparam logic [7:0] FMT_576P = 8'h03;
    localparam logic [7:0] FMT_480P = 8'h04;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_IDWAIT = 2'd1,
        ST_READY  = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/second_timebase.sv
// rtl/second_timebase.sv - one-second tick generator with saturating seconds counter
module second_timebase #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk_50mhz_in,
    input  logic       reset,
    output logic       tick,
    output logic [7:0] elapsed_s
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk_50mhz_in) begin
        if (reset) begin
            cnt       <= '0;
            elapsed_s <= 8'h00;
        end else if (tick) begin
            cnt <= '0;
            if (elapsed_s != 8'hFF)
                elapsed_s <= elapsed_s + 8'h01;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/monitor_irq_sequencer.sv
// rtl/monitor_irq_sequencer.sv - monitor-slot interrupt handshake sequencer (boot, ID, ready, format IRQs)
module monitor_irq_sequencer
    import monitor_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int ID_WAIT_S     = 12,
    parameter int READY_WAIT_S  = 19,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clk_50mhz_in,
    input  logic       reset,
    input  logic       skip_init,
    input  logic       id_read,
    input  logic       irq_ack,
    input  logic [7:0] video_format,
    output logic [7:0] irq_status,
    output logic       int_x,
    output logic [7:0] reg_video_format,
    output logic [7:0] elapsed_s,
    output logic [1:0] seq_state
);

    localparam logic [7:0] ID_LIM    = 8'(ID_WAIT_S);
    localparam logic [7:0] READY_LIM = 8'(READY_WAIT_S);
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] SLAST = SW'(STABLE_CYCLES - 1);

    seq_state_t    state;
    logic          sec_tick;
    logic          id_seen;
    logic          id_time_ok;
    logic          ready_time_ok;
    logic [7:0]    fmt_prev;
    logic [7:0]    fmt_q;
    logic [SW-1:0] stable_cnt;
    logic          post_ok;

    second_timebase #(
        .CLK_HZ(CLK_HZ)
    ) u_timebase (
        .clk_50mhz_in(clk_50mhz_in),
        .reset       (reset),
        .tick        (sec_tick),
        .elapsed_s   (elapsed_s)
    );

    assign post_ok   = (irq_status == IRQ_IDLE) && !irq_ack;
    assign int_x     = (irq_status == IRQ_IDLE);
    assign seq_state = state;

    // Qualified format only moves after STABLE_CYCLES clocks of an unchanged input.
    always_ff @(posedge clk_50mhz_in) begin
        if (reset) begin
            fmt_prev   <= FMT_NONE;
            fmt_q      <= FMT_NONE;
            stable_cnt <= '0;
        end else begin
            fmt_prev <= video_format;
            if (video_format != fmt_prev)
                stable_cnt <= '0;
            else if (stable_cnt == SLAST)
                fmt_q <= fmt_prev;
            else
                stable_cnt <= stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz_in) begin
        if (reset) begin
            state            <= ST_BOOT;
            irq_status       <= IRQ_BOOT;
            reg_video_format <= FMT_NONE;
            id_seen          <= 1'b0;
            id_time_ok       <= 1'b0;
            ready_time_ok    <= 1'b0;
        end else begin
            if (id_read)
                id_seen <= 1'b1;
            // Sticky flags rise on the same edge elapsed_s first exceeds the limit.
            if (sec_tick) begin
                if (elapsed_s >= ID_LIM)
                    id_time_ok <= 1'b1;
                if (elapsed_s >= READY_LIM)
                    ready_time_ok <= 1'b1;
            end
            if (irq_ack)
                irq_status <= IRQ_IDLE;
            case (state)
                ST_BOOT: begin
                    if (irq_ack) begin
                        state <= ST_IDWAIT;
                    end else if (skip_init) begin
                        irq_status <= IRQ_IDLE;
                        state      <= ST_RUN;
                    end
                end
                ST_IDWAIT: begin
                    if (post_ok && id_seen && id_time_ok) begin
                        irq_status <= IRQ_ID;
                        state      <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (post_ok && ready_time_ok) begin
                        irq_status <= IRQ_READY;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (post_ok && (fmt_q != reg_video_format)) begin
                        reg_video_format <= fmt_q;
                        irq_status       <= IRQ_FMT;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_irq_sequencer.sv
// tb/tb_monitor_irq_sequencer.sv - directed self-checking bench for monitor_irq_sequencer
module tb_monitor_irq_sequencer;

    logic       clk_50mhz_in = 1'b0;
    logic       reset        = 1'b1;
    logic       skip_init    = 1'b0;
    logic       id_read      = 1'b0;
    logic       irq_ack      = 1'b0;
    logic [7:0] video_format = 8'h00;
    logic [7:0] irq_status;
    logic       int_x;
    logic [7:0] reg_video_format;
    logic [7:0] elapsed_s;
    logic [1:0] seq_state;

    int total = 0;
    int bad   = 0;

    monitor_irq_sequencer #(
        .CLK_HZ       (100),
        .ID_WAIT_S    (12),
        .READY_WAIT_S (19),
        .STABLE_CYCLES(8)
    ) dut (
        .clk_50mhz_in    (clk_50mhz_in),
        .reset           (reset),
        .skip_init       (skip_init),
        .id_read         (id_read),
        .irq_ack         (irq_ack),
        .video_format    (video_format),
        .irq_status      (irq_status),
        .int_x           (int_x),
        .reg_video_format(reg_video_format),
        .elapsed_s       (elapsed_s),
        .seq_state       (seq_state)
    );

    always #5 clk_50mhz_in = ~clk_50mhz_in;

    task automatic step(input int n);
        repeat (n) @(negedge clk_50mhz_in);
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic wait_elapsed(input string tag, input logic [7:0] target, input int budget);
        int n = 0;
        while (elapsed_s !== target && n < budget) begin
            @(negedge clk_50mhz_in);
            n++;
        end
        check(tag, elapsed_s, target);
    endtask

    initial begin
        // Reset state and idle BOOT with no ack
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_status", irq_status, 8'hFD);
        check("rst_intx", {7'd0, int_x}, 8'h00);
        check("rst_state", {6'd0, seq_state}, 8'h00);
        check("rst_regfmt", reg_video_format, 8'h00);
        check("rst_elapsed", elapsed_s, 8'h00);
        step(250);
        check("boot_hold_status", irq_status, 8'hFD);
        check("boot_hold_intx", {7'd0, int_x}, 8'h00);
        check("boot_hold_state", {6'd0, seq_state}, 8'h00);

        // Ack in BOOT, ID read at 5 s, FB after 12 s exceeded, EF after 19 s exceeded
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("boot_ack_status", irq_status, 8'hFF);
        check("boot_ack_intx", {7'd0, int_x}, 8'h01);
        check("boot_ack_state", {6'd0, seq_state}, 8'h01);
        wait_elapsed("wait_5s", 8'd5, 700);
        id_read = 1'b1;
        step(1);
        id_read = 1'b0;
        wait_elapsed("wait_12s", 8'd12, 800);
        check("id_not_yet_12", irq_status, 8'hFF);
        wait_elapsed("wait_13s", 8'd13, 200);
        check("id_not_yet_13", irq_status, 8'hFF);
        step(1);
        check("id_posted", irq_status, 8'hFB);
        check("id_intx", {7'd0, int_x}, 8'h00);
        check("id_state", {6'd0, seq_state}, 8'h02);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("id_ack", irq_status, 8'hFF);
        wait_elapsed("wait_20s", 8'd20, 800);
        check("ready_not_yet", irq_status, 8'hFF);
        step(1);
        check("ready_posted", irq_status, 8'hEF);
        check("ready_state", {6'd0, seq_state}, 8'h03);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        step(20);
        check("run_idle_no_fmt", irq_status, 8'hFF);

        // skip_init from reset with format 03 already present
        reset        = 1'b1;
        skip_init    = 1'b1;
        video_format = 8'h03;
        step(2);
        reset = 1'b0;
        step(1);
        skip_init = 1'b0;
        check("skip_status", irq_status, 8'hFF);
        check("skip_state", {6'd0, seq_state}, 8'h03);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check($sformatf("fmt_wait_%0d", i), irq_status, 8'hFF);
        end
        step(1);
        check("fmt_df", irq_status, 8'hDF);
        check("fmt_reg03", reg_video_format, 8'h03);

        // Format changes while DF pending coalesce to the last value
        video_format = 8'h01;
        step(12);
        video_format = 8'h04;
        step(12);
        check("coal_pending", irq_status, 8'hDF);
        check("coal_reg_hold", reg_video_format, 8'h03);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("coal_ack", irq_status, 8'hFF);
        step(1);
        check("coal_df", irq_status, 8'hDF);
        check("coal_reg04", reg_video_format, 8'h04);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;

        // Short glitch that returns to the reported value
        video_format = 8'h02;
        step(5);
        video_format = 8'h04;
        step(20);
        check("glitch_status", irq_status, 8'hFF);
        check("glitch_reg", reg_video_format, 8'h04);

        // Ack in the very cycle the post condition first holds
        video_format = 8'h01;
        step(9);
        check("race_pre", irq_status, 8'hFF);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("race_blocked", irq_status, 8'hFF);
        step(1);
        check("race_post", irq_status, 8'hDF);
        check("race_reg", reg_video_format, 8'h01);

        // Reset while FB pending, with a simultaneous ack
        reset        = 1'b1;
        video_format = 8'h00;
        step(2);
        reset   = 1'b0;
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        id_read = 1'b1;
        step(1);
        id_read = 1'b0;
        wait_elapsed("wait_13s_b", 8'd13, 1500);
        step(1);
        check("fb_pending", irq_status, 8'hFB);
        reset   = 1'b1;
        irq_ack = 1'b1;
        step(1);
        reset   = 1'b0;
        irq_ack = 1'b0;
        check("midrst_status", irq_status, 8'hFD);
        check("midrst_state", {6'd0, seq_state}, 8'h00);
        check("midrst_elapsed", elapsed_s, 8'h00);
        check("midrst_intx", {7'd0, int_x}, 8'h00);

        // ID latch cleared by reset; elapsed saturates and the sequence still completes
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        wait_elapsed("wait_255s", 8'hFF, 26000);
        step(200);
        check("sat_elapsed", elapsed_s, 8'hFF);
        check("noid_status", irq_status, 8'hFF);
        check("noid_state", {6'd0, seq_state}, 8'h01);
        id_read = 1'b1;
        step(1);
        id_read = 1'b0;
        step(1);
        check("sat_fb", irq_status, 8'hFB);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        step(1);
        check("sat_ef", irq_status, 8'hEF);
        check("sat_state", {6'd0, seq_state}, 8'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monitor_irq_sequencer.md
# monitor_irq_sequencer

Sequences the card-initiated interrupt handshake of the BKM-68X monitor-slot emulation, running on the 50 MHz board clock. Owns the interrupt status register (host register 0x41) and walks the boot sequence: power-on, ID-read gate, timed ready, then video-format-change notifications. The bus-side monitor interface reads `irq_status` and `reg_video_format` and forwards the host's clear write as `irq_ack`. `int_x` drives the slot interrupt line.

## Interface
- `CLK_HZ`, 50000000: clocks per second tick.
- `ID_WAIT_S`, 12: seconds that must have elapsed, strictly exceeded, before the ID-done IRQ is posted.
- `READY_WAIT_S`, 19: seconds that must have elapsed, strictly exceeded, before the ready IRQ is posted.
- `STABLE_CYCLES`, 1024: clocks `video_format` must hold a constant value before it is qualified.

- `clk_50mhz_in`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `skip_init`  in  1  level; bypasses the boot sequence.
- `id_read`  in  1  level; the host has read the card ID. Already in the clock domain.
- `irq_ack`  in  1  one-cycle pulse; the host wrote register 0x41. Already synchronized.
- `video_format`  in  8  measured format code (00 none, 01 576i, 02 480i, 03 576p, 04 480p).
- `irq_status`  out  8  register 0x41 value; FF means idle.
- `int_x`  out  1  active-low; 0 whenever `irq_status` != FF.
- `reg_video_format`  out  8  format last reported to the host.
- `elapsed_s`  out  8  seconds since reset; saturates at FF.
- `seq_state`  out  2  current state, for debug.

## Operation
- Reset values:
  - `irq_status`=FD, `int_x`=0.
  - `reg_video_format`=00, `elapsed_s`=00.
  - state BOOT; ID latch cleared; stability filter cleared.
- Timebase: the tick counter runs 0..CLK_HZ-1 and emits a one-cycle tick on wrap. Each tick increments `elapsed_s` until it reaches FF, then holds.
- ID latch: set by `id_read`=1 and cleared only by reset.
- Stability filter: compares `video_format` with its registered copy. A mismatch reloads the counter to 0. The value is qualified (`fmt_q`) once the counter reaches STABLE_CYCLES-1. Initial `fmt_q`=00.
- Ack rule: `irq_ack` in any state sets `irq_status`=FF. An ack while `irq_status` is already FF has no effect.
- Post rule: a new code is posted only if `irq_status`==FF at the clock edge and `irq_ack`=0 in that cycle. A post and an ack never occur in the same cycle.
- States and transitions:
  - BOOT (0):
    - `irq_ack` -> FF, go to IDWAIT. `irq_ack` has priority over `skip_init`.
    - else `skip_init` -> `irq_status`=FF, go to RUN.
  - IDWAIT (1): ID latch set and `elapsed_s` > ID_WAIT_S and post allowed -> post FB, go to READY.
  - READY (2): post allowed and `elapsed_s` > READY_WAIT_S -> post EF, go to RUN.
  - RUN (3): post allowed and `fmt_q` != `reg_video_format` -> latch `reg_video_format`=`fmt_q` and post DF in the same edge.
- Coalescing: format changes while DF is pending are not queued. After the ack, the comparison is evaluated again against the latest `fmt_q`, so the last value wins. A change that reverts to the reported value before the ack produces no IRQ.
- `int_x` is decoded combinationally from the `irq_status` register.

## Timing
- Posting latency: one clock from the cycle where all conditions hold to the new `irq_status`.
- Ack latency: `irq_status`=FF on the edge that samples `irq_ack`. A new post can occur no earlier than the following edge.
- Format path latency: a `video_format` change reaches DF in STABLE_CYCLES+1 clocks, measured from the first stable cycle and assuming status idle in RUN.
- `elapsed_s` saturation: times stay satisfied, so there is no deadlock after 255 s.
- Reset mid-sequence: everything returns to reset values on the next edge, regardless of `irq_ack` or a pending post.
- `skip_init` sampled outside BOOT: ignored.

## Structure
- Shared package `monitor_pkg`:
  - IRQ codes: IRQ_BOOT=FD, IRQ_ID=FB, IRQ_READY=EF, IRQ_FMT=DF, IRQ_IDLE=FF.
  - Format codes 00-04.
  - `seq_state` encoding BOOT/IDWAIT/READY/RUN.
- Sub-module `second_timebase`: parameter CLK_HZ; ports `clk_50mhz_in`, `reset`, `tick`, `elapsed_s` (saturating).
- The stability filter and the FSM live in the top module.

## Test plan
The bench uses CLK_HZ=100 and STABLE_CYCLES=8.
- Reset, no acks -> `irq_status`=FD and `int_x`=0 indefinitely; `seq_state`=0.
- Ack in BOOT, `id_read` at 5 s -> FF at the ack edge; FB appears at the first edge with `elapsed_s`=13, not before, one clock after the condition holds. A second ack, then EF when `elapsed_s`=20. Final `seq_state`=3.
- `skip_init`=1 at reset release, `video_format`=03 -> RUN and FF immediately; DF plus `reg_video_format`=03 about 9 clocks after `video_format` became stable.
- In RUN with DF pending, `video_format` 03->01->04 (each stable) -> no post until the ack; after the ack, DF is posted one edge later with `reg_video_format`=04.
- Glitch on `video_format` lasting 5 clocks, then back to the reported value -> no DF, and `irq_status` stays FF.
- `irq_ack` in the exact cycle a post condition becomes true, and `reset` asserted while FB is pending -> no post that cycle (post next edge); reset yields FD/BOOT/`elapsed_s`=00.
